// File: rtl/ht_ltf_rx_capture.sv
// ht_ltf_rx_capture
// Receive-side HT-LTF capture. After a start pulse, discards CP_LEN
// cyclic-prefix samples and captures the next 64 strobed samples into a local
// buffer. It then streams the buffer to the FFT/channel-estimation stage
// through a valid/ready handshake.
//
// Optional build: define HT_LTF_RX_CAPTURE_DC_EN to estimate the DC offset
// over the captured symbol and subtract it, with saturation, from every
// streamed word. This build adds the dc_i/dc_q ports.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start              one-cycle pulse; the next accepted strobe is CP sample 0
//   sample_in[31:0]    {I, Q}, each signed 16-bit
//   sample_in_strobe   sample_in valid this cycle
//   out_data[31:0]     buffered {I, Q} word
//   out_valid          out_data valid
//   out_ready          downstream accepts when out_valid & out_ready
//   out_index[5:0]     index 0..63 of out_data
//   out_last           high with out_valid when out_index == 63
//   busy               high in any state except IDLE
//   drop_err           sticky: a strobe arrived during DRAIN and was lost
//   dc_i, dc_q         (DC build only) DC estimates latched on DRAIN entry
//
// state   | meaning
// IDLE    | waiting for start; strobes ignored
// SKIP_CP | down-counting cyclic-prefix strobes to terminal count
// CAPTURE | writing strobed samples to mem[cnt]
// DRAIN   | streaming mem[0..63] downstream
module ht_ltf_rx_capture #(
  parameter int CP_LEN  = 16,
  parameter int SYM_LEN = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] sample_in,
  input  logic        sample_in_strobe,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        drop_err
`ifdef HT_LTF_RX_CAPTURE_DC_EN
  ,
  output logic [15:0] dc_i,
  output logic [15:0] dc_q
`endif
);

  typedef enum logic [1:0] {IDLE, SKIP_CP, CAPTURE, DRAIN} state_t;

  localparam logic [5:0] CP_LAST  = 6'(CP_LEN - 1);
  localparam logic [5:0] SYM_LAST = 6'(SYM_LEN - 1);

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] mem [0:63];
  logic [5:0]  rd_addr;
  logic [31:0] rd_word;
  logic [31:0] out_word;
  logic        cp_done, cap_done, hs, drain_done;

  assign cp_done    = (state == SKIP_CP) && sample_in_strobe && (cnt == 6'd0);
  assign cap_done   = (state == CAPTURE) && sample_in_strobe && (cnt == SYM_LAST);
  assign hs         = out_valid && out_ready;
  assign drain_done = hs && (out_index == SYM_LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = SKIP_CP;
      SKIP_CP: if (cp_done)    state_nxt = CAPTURE;
      CAPTURE: if (cap_done)   state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Shared counter: CP down-counter with terminal count at 0, then the
  // capture write address counting up (wraps to 0 after index 63).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 6'd0;
    end else begin
      case (state)
        IDLE:    if (start) cnt <= CP_LAST;
        SKIP_CP: if (sample_in_strobe) cnt <= cp_done ? 6'd0 : cnt - 6'd1;
        CAPTURE: if (sample_in_strobe) cnt <= cnt + 6'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CAPTURE && sample_in_strobe) mem[cnt] <= sample_in;
  end

  // Prefetch: the output register loads word 0 on the final capture strobe
  // and word rd+1 on each handshake, so streaming runs at one word per cycle.
  assign rd_addr = (state == CAPTURE) ? 6'd0 : out_index + 6'd1;
  assign rd_word = mem[rd_addr];

`ifdef HT_LTF_RX_CAPTURE_DC_EN
  logic [21:0] sum_i, sum_q, sum_i_nxt, sum_q_nxt;
  logic [15:0] dc_i_use, dc_q_use;

  function automatic logic [15:0] sub_sat(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15]) sub_sat = d[16] ? 16'h8000 : 16'h7fff;
    else                sub_sat = d[15:0];
  endfunction

  assign sum_i_nxt = sum_i + {{6{sample_in[31]}}, sample_in[31:16]};
  assign sum_q_nxt = sum_q + {{6{sample_in[15]}}, sample_in[15:0]};

  // Word 0 is loaded in the same cycle the estimate is latched, so it uses
  // the estimate that includes the final sample.
  assign dc_i_use = (state == CAPTURE) ? sum_i_nxt[21:6] : dc_i;
  assign dc_q_use = (state == CAPTURE) ? sum_q_nxt[21:6] : dc_q;
  assign out_word = {sub_sat(rd_word[31:16], dc_i_use), sub_sat(rd_word[15:0], dc_q_use)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_i <= 22'd0;
      sum_q <= 22'd0;
      dc_i  <= 16'd0;
      dc_q  <= 16'd0;
    end else begin
      if (state == IDLE && start) begin
        sum_i <= 22'd0;
        sum_q <= 22'd0;
      end else if (state == CAPTURE && sample_in_strobe) begin
        sum_i <= sum_i_nxt;
        sum_q <= sum_q_nxt;
      end
      if (cap_done) begin
        dc_i <= sum_i_nxt[21:6];
        dc_q <= sum_q_nxt[21:6];
      end
    end
  end
`else
  assign out_word = rd_word;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
    end else if (cap_done) begin
      out_valid <= 1'b1;
      out_data  <= out_word;
      out_index <= 6'd0;
      out_last  <= 1'b0;
    end else if (hs) begin
      if (out_index == SYM_LAST) begin
        out_valid <= 1'b0;
        out_index <= 6'd0;
        out_last  <= 1'b0;
      end else begin
        out_data  <= out_word;
        out_index <= out_index + 6'd1;
        out_last  <= (out_index + 6'd1 == SYM_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 drop_err <= 1'b0;
    else if (state == IDLE && start)           drop_err <= 1'b0;
    else if (state == DRAIN && sample_in_strobe) drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_ht_ltf_rx_capture.sv
module tb_ht_ltf_rx_capture;
  localparam int CP = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] sample_in = 32'd0;
  logic        sample_in_strobe = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [5:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        drop_err;
`ifdef HT_LTF_RX_CAPTURE_DC_EN
  logic [15:0] dc_i, dc_q;
  int          exp_dci, exp_dcq;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] stim[$];
  logic [31:0] expq[$];

  ht_ltf_rx_capture #(.CP_LEN(CP), .SYM_LEN(64)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .sample_in(sample_in), .sample_in_strobe(sample_in_strobe),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .busy(busy), .drop_err(drop_err)
`ifdef HT_LTF_RX_CAPTURE_DC_EN
    , .dc_i(dc_i), .dc_q(dc_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int floor_div64(input int s);
    if (s >= 0) return s / 64;
    return -((-s + 63) / 64);
  endfunction

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Reference: the symbol is strobes CP..CP+63 after start; optionally minus
  // the floor of its mean, clamped to the signed 16-bit range.
  task automatic build_exp();
    logic [31:0] w;
    int si, sq;
    si = 0; sq = 0;
    expq.delete();
    for (int n = 0; n < 64; n++) begin
      w = stim[CP + n];
      si += int'($signed(w[31:16]));
      sq += int'($signed(w[15:0]));
    end
`ifdef HT_LTF_RX_CAPTURE_DC_EN
    exp_dci = floor_div64(si);
    exp_dcq = floor_div64(sq);
`endif
    for (int n = 0; n < 64; n++) begin
      w = stim[CP + n];
`ifdef HT_LTF_RX_CAPTURE_DC_EN
      expq.push_back({sat16(int'($signed(w[31:16])) - exp_dci),
                      sat16(int'($signed(w[15:0])) - exp_dcq)});
`else
      expq.push_back(w);
`endif
    end
  endtask

  task automatic run_symbol(input int gap, input bit tog, input bit mid_start, input bit do_drop);
    int sent, nout;
    bit expect_valid, was_stalled, mid_done, drop_done, drop_pend;
    logic [31:0] hold_d;
    logic [5:0]  hold_i;
    build_exp();
    start = 1'b1; sample_in_strobe = 1'b1; sample_in = 32'hdead_beef; out_ready = 1'b0;
    tick();
    start = 1'b0; sample_in_strobe = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("drop_err_cleared", 32'(drop_err), 32'd0);
    sent = 0; nout = 0;
    expect_valid = 0; was_stalled = 0; mid_done = 0; drop_done = 0; drop_pend = 0;
    for (int cyc = 0; cyc < 3000 && nout < 64; cyc++) begin
      chk("busy_hold", 32'(busy), 32'd1);
      if (expect_valid) begin
        chk("first_valid_latency", 32'(out_valid), 32'd1);
        expect_valid = 0;
      end else if (sent < CP + 64) begin
        chk("no_early_valid", 32'(out_valid), 32'd0);
      end
      if (was_stalled) begin
        chk("hold_data", out_data, hold_d);
        chk("hold_index", 32'(out_index), 32'(hold_i));
      end
      if (drop_pend) begin
        chk("drop_err_set", 32'(drop_err), 32'd1);
        drop_pend = 0;
      end
      start = 1'b0;
      if (mid_start && !mid_done && sent == CP + 10) begin
        start = 1'b1;
        mid_done = 1;
      end
      sample_in_strobe = 1'b0;
      if (sent < stim.size() && cyc % gap == 0) begin
        sample_in_strobe = 1'b1;
        sample_in = stim[sent];
        sent++;
        if (sent == CP + 64) expect_valid = 1;
      end
      out_ready = tog ? (cyc % 2 == 0) : 1'b1;
      if (do_drop && !drop_done && nout == 5 && out_valid) begin
        out_ready = 1'b0;
        sample_in_strobe = 1'b1;
        sample_in = 32'h1234_5678;
        drop_done = 1;
        drop_pend = 1;
      end
      was_stalled = out_valid && !out_ready;
      hold_d = out_data;
      hold_i = out_index;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, expq[nout]);
        chk("out_index", 32'(out_index), 32'(nout));
        chk("out_last", 32'(out_last), 32'(nout == 63));
        nout++;
      end
      tick();
    end
    start = 1'b0; sample_in_strobe = 1'b0;
    chk("word_count", 32'(nout), 32'd64);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("valid_fall", 32'(out_valid), 32'd0);
    chk("drop_err_end", 32'(drop_err), 32'(do_drop));
`ifdef HT_LTF_RX_CAPTURE_DC_EN
    chk("dc_i", 32'(dc_i), 32'(16'(exp_dci)));
    chk("dc_q", 32'(dc_q), 32'(16'(exp_dcq)));
`endif
  endtask

  task automatic fill_ramp();
    logic [15:0] k;
    stim.delete();
    for (int i = 0; i < CP + 64; i++) begin
      k = 16'(i);
      stim.push_back({k, -k});
    end
  endtask

  task automatic fill_random();
    stim.delete();
    for (int i = 0; i < CP + 64; i++) stim.push_back($urandom);
  endtask

  initial begin
    // reset values
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_err), 32'd0);
    rstn = 1'b1;
    tick();

    // strobes in IDLE are ignored
    for (int i = 0; i < 20; i++) begin
      sample_in_strobe = 1'b1; sample_in = $urandom;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);
    end
    sample_in_strobe = 1'b0;

    // 1: basic ramp capture, back-to-back
    fill_ramp();
    run_symbol(1, 0, 0, 0);
    chk("ramp_word0", expq[0], {16'd16, -16'd16});

    // 2: gapped input with toggling backpressure
    fill_random();
    run_symbol(3, 1, 0, 0);

    // 3: start while busy is ignored
    fill_ramp();
    run_symbol(1, 0, 1, 0);

    // 4: dropped strobe during DRAIN; sticky, then cleared by next start
    fill_random();
    run_symbol(2, 0, 0, 1);
    repeat (3) tick();
    chk("drop_sticky_idle", 32'(drop_err), 32'd1);
    fill_random();
    run_symbol(1, 1, 0, 0);

    // 5: reset at CAPTURE cnt=30
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < CP + 30; i++) begin
      sample_in_strobe = 1'b1; sample_in = $urandom;
      tick();
    end
    sample_in_strobe = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #2;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_index", 32'(out_index), 32'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 70; i++) begin
      sample_in_strobe = 1'b1; sample_in = $urandom;
      tick();
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end
    sample_in_strobe = 1'b0;
    fill_random();
    run_symbol(1, 0, 0, 0);

`ifdef HT_LTF_RX_CAPTURE_DC_EN
    // 6a: constant symbol removes to zero
    stim.delete();
    for (int i = 0; i < CP + 64; i++) stim.push_back(32'h0105_ff00);
    run_symbol(1, 0, 0, 0);
    chk("dc_i_const", 32'(dc_i), 32'h0105);
    chk("dc_q_const", 32'(dc_q), 32'hff00);
    // 6b: alternating extremes drive dc_i negative; 32767 saturates
    stim.delete();
    for (int i = 0; i < CP + 64; i++)
      stim.push_back({(i % 2 == 0) ? 16'h8000 : 16'h7fff, 16'($urandom)});
    run_symbol(1, 1, 0, 0);
    chk("dc_i_neg", 32'(dc_i), 32'hffff);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ht_ltf_rx_capture.md
Name: ht_ltf_rx_capture

Overview:
- Receive-side counterpart of the transmit HT-LTF sample generator.
- Triggered at the expected start of an HT-LTF symbol.
- Discards the cyclic prefix, captures the 64-sample useful part into a local buffer, then streams it to the FFT/channel-estimation stage with a valid/ready handshake.
- Sits between the RX sample path (after CFO correction) and the FFT input mux.

Parameters:
- CP_LEN, 16, number of cyclic-prefix samples discarded after start (range 1..63).
- SYM_LEN, 64, useful samples captured per symbol; fixed at 64. Other values are unsupported.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; the next accepted strobe is CP sample 0.
- sample_in  in  32  {I[31:16], Q[15:0]}, each signed 16-bit two's complement.
- sample_in_strobe  in  1  sample_in valid this cycle.
- out_data  out  32  {I,Q} buffered sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_index  out  6  index 0..63 of out_data.
- out_last  out  1  high with out_valid when out_index==63.
- busy  out  1  high in any state except IDLE.
- drop_err  out  1  sticky; a strobe arrived in DRAIN and was lost. Cleared by start or reset.

Behaviour:
- Reset (async, rstn=0):
  - State=IDLE; all counters 0.
  - out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, drop_err=0.
  - Buffer contents undefined.
- States and transitions:
  - IDLE: start=1 -> SKIP_CP, cnt=0, drop_err cleared. Strobes are ignored.
  - SKIP_CP: each strobe increments cnt. On the strobe where cnt==CP_LEN-1 -> CAPTURE, cnt=0. The sample is discarded.
  - CAPTURE: each strobe writes sample_in to buf[cnt] and increments cnt. On the strobe where cnt==63 -> DRAIN, rd=0.
  - DRAIN: out_valid=1, out_data=buf[rd], out_index=rd, out_last=(rd==63).
    - On handshake, rd increments and the next word is presented the following cycle. Throughput is 1 word/cycle when out_ready is held high.
    - Handshake at rd==63 -> IDLE; out_valid falls the next cycle.
- Latency: first out_valid appears the cycle after the 64th captured strobe.
- Output registers: out_data, out_index and out_last are registered. They must hold stable while out_valid=1 and out_ready=0.
- Start handling:
  - start while busy is ignored. No restart and no error.
  - start and a strobe in the same IDLE cycle: that strobe is not counted.
- drop_err: sample_in_strobe in DRAIN sets it. The sample is discarded and the state is unaffected.
- busy = (state != IDLE).
- Buffer: 64x32, one write port, one read port. Either distributed or block RAM is acceptable. Registered read must still meet the one-word-per-cycle DRAIN rate (prefetch as required).
- Reset mid-operation: returns immediately to IDLE with all outputs at reset values. A partial capture is never emitted.

Optional Feature:
- Macro: HT_LTF_RX_CAPTURE_DC_EN.
- With the macro defined, during CAPTURE:
  - Accumulate the signed 22-bit sums of I and of Q over the 64 samples. Accumulators clear on entry to SKIP_CP.
  - On entry to DRAIN: dc_i = sum_i >>> 6, dc_q = sum_q >>> 6 (arithmetic shift, truncation toward -inf).
  - Each out_data half = sample - dc, saturated to [-32768, 32767].
  - Extra ports: dc_i out 16, dc_q out 16. Both are registered, reset 0, and held until the next DRAIN entry.
  - Latency is unchanged.
- Without the macro: no accumulators, no dc ports, out_data is the raw buffered sample.

Test Plan:
1. Basic capture:
   - Stimulus: reset, start, then 80 back-to-back strobes with sample k = {k[15:0], -k[15:0]}, out_ready=1.
   - Required: 64 outputs with out_data = {16+n, -(16+n)} for n=0..63; out_last only at n=63; busy falls 1 cycle after the last handshake.
2. Gapped input and backpressure:
   - Stimulus: strobe every 3rd cycle; out_ready toggled 1/0 each cycle.
   - Required: same 64 words in order; out_data/out_index stable while out_ready=0; no drop_err.
3. Start while busy:
   - Stimulus: second start pulse at CAPTURE cnt=10.
   - Required: ignored; output identical to scenario 1.
4. Dropped sample:
   - Stimulus: strobe during DRAIN with out_ready=0.
   - Required: drop_err=1 and stays 1 after IDLE. Next start clears it to 0.
5. Reset mid-operation:
   - Stimulus: rstn=0 for 1 cycle at CAPTURE cnt=30, then a fresh start plus 80 strobes.
   - Required: outputs at reset values immediately; no stale words emitted; new capture correct.
6. DC removal (macro defined):
   - Stimulus: all 64 captured samples = {0x0105, 0xFF00}.
   - Required: dc_i=0x0105, dc_q=0xFF00, every out_data=0x00000000.
   - Stimulus: samples I=32767 with dc forced negative via alternating -32768/32767.
   - Required: saturation to 32767, no wrap.
